// File: rtl/alu_mdu_pkg.sv
// Shared encodings for the execute-stage ALU and the iterative multiply/divide unit.
// Provides the ALU and MDU opcodes, the MDU FSM states and a small decode helper.
package alu_mdu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } mdu_state_e;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Execute-stage bus: ALU operands/result plus the MDU start/busy/done handshake and HI/LO.
// The stage driving the unit uses master; alu_mdu itself uses slave.
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALUcontrol;
    logic [WIDTH-1:0] Y;
    logic             Z;
    logic [1:0]       md_op;
    logic             start;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output A, B, ALUcontrol, md_op, start, hi_we, lo_we,
        input  Y, Z, busy, done, hi, lo
    );

    modport slave (
        input  A, B, ALUcontrol, md_op, start, hi_we, lo_we,
        output Y, Z, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_mdu_core.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Operands are reduced to magnitudes at start; signs are re-applied on the FIN edge.
module mdu_core
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       md_op,
    input  logic             start,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg, acc_step;
    logic [WIDTH-1:0]   opnd_reg, raw_a_reg;
    logic               is_div_reg, neg_q_reg, neg_r_reg, div_zero_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg, hi_fin, lo_fin;
    logic               last_step;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    assign last_step = (cnt_reg == CW'(WIDTH - 1));
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_FIN);
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    always_comb begin
        sa    = md_is_signed(md_op) & a[WIDTH-1];
        sb    = md_is_signed(md_op) & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
        rem_sh = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_reg};
        if (is_div_reg) begin
            if (diff[WIDTH])
                acc_step = {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
            else
                acc_step = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            if (acc_reg[0])
                acc_step = {sum, acc_reg[WIDTH-1:1]};
            else
                acc_step = {1'b0, acc_reg[2*WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = neg_q_reg ? -acc_step : acc_step;
        quot   = acc_step[WIDTH-1:0];
        rem    = acc_step[2*WIDTH-1:WIDTH];
        hi_fin = prod[2*WIDTH-1:WIDTH];
        lo_fin = prod[WIDTH-1:0];
        if (is_div_reg) begin
            if (div_zero_reg) begin
                lo_fin = '1;
                hi_fin = raw_a_reg;
            end else begin
                lo_fin = neg_q_reg ? -quot : quot;
                hi_fin = neg_r_reg ? -rem  : rem;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            raw_a_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (hi_we) hi_reg <= a;
                    if (lo_we) lo_reg <= a;
                    if (start) begin
                        cnt_reg      <= '0;
                        acc_reg      <= {{WIDTH{1'b0}}, mag_a};
                        opnd_reg     <= mag_b;
                        raw_a_reg    <= a;
                        is_div_reg   <= md_op[1];
                        neg_q_reg    <= sa ^ sb;
                        neg_r_reg    <= sa;
                        div_zero_reg <= (b == '0);
                    end
                end
                ST_RUN: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_step) begin
                        hi_reg <= hi_fin;
                        lo_reg <= lo_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational single-cycle ops plus one iterative MDU with HI/LO.
// Y/Z never depend on the MDU state.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_mdu_if.slave    bus
);

    always_comb begin
        bus.Y = '0;
        case (alu_op_e'(bus.ALUcontrol))
            ALU_ADD:  bus.Y = bus.A + bus.B;
            ALU_SUB:  bus.Y = bus.A - bus.B;
            ALU_AND:  bus.Y = bus.A & bus.B;
            ALU_OR:   bus.Y = bus.A | bus.B;
            ALU_XOR:  bus.Y = bus.A ^ bus.B;
            ALU_NOR:  bus.Y = ~(bus.A | bus.B);
            ALU_SLT:  bus.Y = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            ALU_SLTU: bus.Y = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
            default:  bus.Y = '0;
        endcase
    end

    assign bus.Z = (bus.Y == '0);

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .a     (bus.A),
        .b     (bus.B),
        .md_op (bus.md_op),
        .start (bus.start),
        .hi_we (bus.hi_we),
        .lo_we (bus.lo_we),
        .busy  (bus.busy),
        .done  (bus.done),
        .hi    (bus.hi),
        .lo    (bus.lo)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu at WIDTH=32 and WIDTH=8: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) bus32 ();
    alu_mdu_if #(.WIDTH(8))  bus8 ();

    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    logic [31:0] a_drv, b_drv;
    logic [2:0]  ctl_drv;
    logic [1:0]  op_drv;
    logic        st_drv, hwe_drv, lwe_drv, sel8;

    assign bus32.A          = a_drv;
    assign bus32.B          = b_drv;
    assign bus32.ALUcontrol = ctl_drv;
    assign bus32.md_op      = op_drv;
    assign bus32.start      = st_drv  & ~sel8;
    assign bus32.hi_we      = hwe_drv & ~sel8;
    assign bus32.lo_we      = lwe_drv & ~sel8;
    assign bus8.A           = a_drv[7:0];
    assign bus8.B           = b_drv[7:0];
    assign bus8.ALUcontrol  = ctl_drv;
    assign bus8.md_op       = op_drv;
    assign bus8.start       = st_drv  & sel8;
    assign bus8.hi_we       = hwe_drv & sel8;
    assign bus8.lo_we       = lwe_drv & sel8;

    logic [31:0] y_o, hi_o, lo_o;
    logic        z_o, busy_o, done_o;
    assign y_o    = sel8 ? {24'b0, bus8.Y}  : bus32.Y;
    assign hi_o   = sel8 ? {24'b0, bus8.hi} : bus32.hi;
    assign lo_o   = sel8 ? {24'b0, bus8.lo} : bus32.lo;
    assign z_o    = sel8 ? bus8.Z    : bus32.Z;
    assign busy_o = sel8 ? bus8.busy : bus32.busy;
    assign done_o = sel8 ? bus8.done : bus32.done;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input int w, input longint u);
        return (u >= (longint'(1) << (w - 1))) ? u - (longint'(1) << w) : u;
    endfunction

    function automatic logic [31:0] alu_ref(input int w, input logic [2:0] ctl,
                                            input logic [31:0] a, input logic [31:0] b);
        longint m, ua, ub, r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        case (ctl)
            3'd0: r = ua + ub;
            3'd1: r = ua - ub;
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = ~(ua | ub);
            3'd6: r = (sx(w, ua) < sx(w, ub)) ? 1 : 0;
            default: r = (ua < ub) ? 1 : 0;
        endcase
        return 32'(r & m);
    endfunction

    // Truncating division semantics of longint '/' and '%' match the architectural rules.
    task automatic md_ref(input int w, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
        longint m, ua, ub, p, q, r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        if (op[1] == 1'b0) begin
            p  = (op == 2'd0) ? sx(w, ua) * sx(w, ub) : ua * ub;
            eh = 32'((p >> w) & m);
            el = 32'(p & m);
        end else if (ub == 0) begin
            el = 32'(m);
            eh = 32'(ua);
        end else begin
            q  = (op == 2'd2) ? sx(w, ua) / sx(w, ub) : ua / ub;
            r  = (op == 2'd2) ? sx(w, ua) % sx(w, ub) : ua % ub;
            el = 32'(q & m);
            eh = 32'(r & m);
        end
    endtask

    task automatic do_alu(input logic s8, input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        int w;
        w = s8 ? 8 : 32;
        sel8 = s8; ctl_drv = ctl; a_drv = a; b_drv = b;
        #1;
        e = alu_ref(w, ctl, a, b);
        check($sformatf("alu%0d_op%0d_y", w, ctl), 64'(y_o), 64'(e));
        check($sformatf("alu%0d_op%0d_z", w, ctl), 64'(z_o), 64'(e == 0));
        $display("alu w=%0d op=%0d a=%h b=%h y=%h z=%0b", w, ctl, a, b, y_o, z_o);
    endtask

    task automatic do_md(input logic s8, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hwe_start, input logic poke);
        logic [31:0] eh, el, amask;
        int w, lat;
        logic busy_ok;
        w = s8 ? 8 : 32;
        amask = s8 ? (a & 32'hff) : a;
        md_ref(w, op, a, b, eh, el);
        sel8 = s8; a_drv = a; b_drv = b; op_drv = op;
        st_drv = 1'b1; hwe_drv = hwe_start; lwe_drv = 1'b0;
        @(posedge clk); #1;
        st_drv = 1'b0; hwe_drv = 1'b0;
        if (hwe_start) check("hwe_with_start", 64'(hi_o), 64'(amask));
        a_drv = $urandom; b_drv = $urandom; op_drv = 2'($urandom);
        lat = 0; busy_ok = 1'b1;
        while (done_o !== 1'b1 && lat < 200) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (poke && lat == 5) begin
                st_drv = 1'b1; hwe_drv = 1'b1; lwe_drv = 1'b1; a_drv = 32'h55;
            end else begin
                st_drv = 1'b0; hwe_drv = 1'b0; lwe_drv = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("md_latency", 64'(lat), 64'(w));
        check("md_busy_run", 64'(busy_ok), 64'd1);
        check("md_busy_fin", 64'(busy_o), 64'd1);
        check("md_hi", 64'(hi_o), 64'(eh));
        check("md_lo", 64'(lo_o), 64'(el));
        if (poke) begin
            st_drv = 1'b1; hwe_drv = 1'b1; lwe_drv = 1'b1; a_drv = 32'h55;
        end
        @(posedge clk); #1;
        st_drv = 1'b0; hwe_drv = 1'b0; lwe_drv = 1'b0;
        check("md_idle_busy", 64'(busy_o), 64'd0);
        check("md_idle_done", 64'(done_o), 64'd0);
        check("md_hold_hi", 64'(hi_o), 64'(eh));
        check("md_hold_lo", 64'(lo_o), 64'(el));
        $display("md w=%0d op=%0d a=%h b=%h hi=%h lo=%h lat=%0d", w, op, a, b, hi_o, lo_o, lat);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        no_done;
        reset = 1'b1; sel8 = 1'b0;
        a_drv = '0; b_drv = '0; ctl_drv = '0; op_drv = '0;
        st_drv = 1'b0; hwe_drv = 1'b0; lwe_drv = 1'b0;
        #12;
        check("rst_hi32", 64'(bus32.hi), 64'd0);
        check("rst_lo32", 64'(bus32.lo), 64'd0);
        check("rst_busy32", 64'(bus32.busy), 64'd0);
        check("rst_done32", 64'(bus32.done), 64'd0);
        check("rst_busy8", 64'(bus8.busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_alu(1'b0, ALU_ADD, 32'd25, 32'd100);
        check("add_125", 64'(y_o), 64'd125);
        do_alu(1'b0, ALU_SUB, 32'h2222, 32'h2222);
        check("sub_zero_z", 64'(z_o), 64'd1);
        do_alu(1'b0, ALU_SLT, 32'hfffff345, 32'h7354);
        check("slt_neg", 64'(y_o), 64'd1);
        do_alu(1'b0, ALU_SLTU, 32'hfffff345, 32'h7354);
        check("sltu_big", 64'(y_o), 64'd0);
        for (int i = 0; i < 24; i++) begin
            do_alu(1'b0, 3'($urandom), $urandom, $urandom);
            do_alu(1'b1, 3'($urandom), $urandom, $urandom);
        end

        do_md(1'b0, MD_MULT, 32'hfffffffd, 32'd7, 1'b0, 1'b0);
        check("mult_hi", 64'(hi_o), 64'hffffffff);
        check("mult_lo", 64'(lo_o), 64'hffffffeb);
        do_md(1'b0, MD_DIV, 32'hfffffff9, 32'd2, 1'b0, 1'b0);
        check("div_q", 64'(lo_o), 64'hfffffffd);
        check("div_r", 64'(hi_o), 64'hffffffff);
        do_md(1'b0, MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        check("divu_q", 64'(lo_o), 64'd3);
        check("divu_r", 64'(hi_o), 64'd1);
        do_md(1'b0, MD_DIVU, 32'h1234, 32'd0, 1'b0, 1'b0);
        check("div0_lo", 64'(lo_o), 64'hffffffff);
        check("div0_hi", 64'(hi_o), 64'h1234);
        do_md(1'b0, MD_DIV, 32'h80000000, 32'hffffffff, 1'b0, 1'b0);
        check("divmin_lo", 64'(lo_o), 64'h80000000);
        check("divmin_hi", 64'(hi_o), 64'd0);
        do_md(1'b0, MD_DIV, 32'hfffffff9, 32'd0, 1'b0, 1'b0);
        do_md(1'b0, MD_MULTU, 32'hfffffffd, 32'd7, 1'b0, 1'b1);

        sel8 = 1'b0; a_drv = 32'h55; hwe_drv = 1'b1;
        @(posedge clk); #1;
        hwe_drv = 1'b0;
        check("mthi_idle", 64'(hi_o), 64'h55);
        $display("mthi a=%h hi=%h", 32'h55, hi_o);
        do_md(1'b0, MD_MULTU, 32'd9, 32'd9, 1'b1, 1'b0);

        do_md(1'b1, MD_MULT, 32'hfd, 32'd7, 1'b0, 1'b0);
        check("mult8_prod", 64'({hi_o[7:0], lo_o[7:0]}), 64'hffeb);
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            do_md(1'b0, 2'($urandom), ra, rb, 1'b0, 1'b0);
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            do_md(1'b1, 2'($urandom), ra, rb, 1'b0, 1'b0);
        end

        // Abort a mult in flight with an asynchronous reset.
        sel8 = 1'b0; a_drv = 32'habc; hwe_drv = 1'b1; lwe_drv = 1'b1;
        @(posedge clk); #1;
        hwe_drv = 1'b0; lwe_drv = 1'b0;
        check("pre_rst_hi", 64'(hi_o), 64'habc);
        a_drv = 32'hfffffffd; b_drv = 32'd7; op_drv = MD_MULT; st_drv = 1'b1;
        @(posedge clk); #1;
        st_drv = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_done", 64'(done_o), 64'd0);
        check("abort_hi", 64'(hi_o), 64'd0);
        check("abort_lo", 64'(lo_o), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        no_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_o !== 1'b0 || busy_o !== 1'b0) no_done = 1'b0;
        end
        check("abort_quiet", 64'(no_done), 64'd1);
        check("abort_hi_kept", 64'(hi_o), 64'd0);
        $display("abort hi=%h lo=%h busy=%0b", hi_o, lo_o, busy_o);
        do_md(1'b0, MD_MULT, 32'hfffffffd, 32'd7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
